// File: rtl/lamp_sequence_checker.sv
// Far-end checker for the one-hot RGY lamp bus: decodes colour, enforces R->G->Y->R order and dwell limits.
// All outputs registered, 1-cycle latency from the light sample; no backpressure, one sample accepted every clock.
module lamp_sequence_checker #(
  parameter int DWELL_MIN = 1,
  parameter int DWELL_MAX = 4,
  parameter int LOCK_CNT  = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [0:2]       light,
  output logic [1:0]       color_code,
  output logic             illegal_code,
  output logic             seq_error,
  output logic             dwell_error,
  output logic             lock,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] error_count
);

  localparam int DW = $clog2(DWELL_MAX + 2);
  localparam int TW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [DW-1:0] DW_MAX = DW'(DWELL_MAX);
  localparam logic [DW-1:0] DW_TOP = DW'(DWELL_MAX + 1);
  localparam logic [DW-1:0] DW_MIN = DW'(DWELL_MIN);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CNT);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic          checked;
  logic [TW-1:0] trans;

  logic [1:0]    cur;
  logic [1:0]    succ_col;
  logic          ill, same, succ, seq, dwl, err;
  logic [TW-1:0] trans_nxt;

  always_comb begin
    cur = 2'd0;
    case (light)
      3'b100:  cur = 2'd1;
      3'b010:  cur = 2'd2;
      3'b001:  cur = 2'd3;
      default: cur = 2'd0;
    endcase

    succ_col = 2'd1;
    case (color_code)
      2'd1:    succ_col = 2'd2;
      2'd2:    succ_col = 2'd3;
      default: succ_col = 2'd1;
    endcase

    // In TRACK, color_code always holds the recorded colour of the current segment.
    ill  = (cur == 2'd0);
    same = !ill && (state == TRACK) && (cur == color_code);
    succ = !ill && (state == TRACK) && (cur == succ_col);
    seq  = !ill && (state == TRACK) && !same && !succ;
    dwl  = (same && checked && (dwell == DW_MAX)) ||
           (succ && checked && (dwell < DW_MIN));
    err  = ill | seq | dwl;

    trans_nxt = trans;
    if (err)
      trans_nxt = '0;
    else if (succ && (trans != T_LOCK))
      trans_nxt = trans + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= HUNT;
      dwell        <= '0;
      checked      <= 1'b0;
      trans        <= '0;
      color_code   <= 2'd0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      dwell_error  <= 1'b0;
      lock         <= 1'b0;
      cycle_count  <= '0;
      error_count  <= '0;
    end else begin
      color_code   <= cur;
      illegal_code <= ill;
      seq_error    <= seq;
      dwell_error  <= dwl;
      trans        <= trans_nxt;
      lock         <= (trans_nxt == T_LOCK);

      if (err && (error_count != '1))
        error_count <= error_count + 1'b1;
      if (succ && (cur == 2'd1))
        cycle_count <= cycle_count + 1'b1;

      // Only a legal successor arms dwell checking; entry from HUNT or an out-of-order jump is partial.
      if (ill) begin
        state   <= HUNT;
        dwell   <= '0;
        checked <= 1'b0;
      end else if (state == HUNT) begin
        state   <= TRACK;
        dwell   <= DW'(1);
        checked <= 1'b0;
      end else if (same) begin
        if (dwell != DW_TOP)
          dwell <= dwell + 1'b1;
      end else begin
        dwell   <= DW'(1);
        checked <= succ;
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequence_checker.sv
// Bench for lamp_sequence_checker: three parameter variants share one stimulus stream and a rule-level model.
module tb_lamp_sequence_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [0:2] light;
  logic [1:0] code [3];
  logic       ill [3], seq [3], dwl [3], lck [3];
  logic [7:0] cyc0, err0, cyc1, err1;
  logic [1:0] cyc2, err2;

  int nvec = 0;
  int nerr = 0;

  lamp_sequence_checker u0 (
    .clock(clock), .reset_n(reset_n), .light(light), .color_code(code[0]),
    .illegal_code(ill[0]), .seq_error(seq[0]), .dwell_error(dwl[0]), .lock(lck[0]),
    .cycle_count(cyc0), .error_count(err0));

  lamp_sequence_checker #(.DWELL_MIN(2)) u1 (
    .clock(clock), .reset_n(reset_n), .light(light), .color_code(code[1]),
    .illegal_code(ill[1]), .seq_error(seq[1]), .dwell_error(dwl[1]), .lock(lck[1]),
    .cycle_count(cyc1), .error_count(err1));

  lamp_sequence_checker #(.CNT_W(2)) u2 (
    .clock(clock), .reset_n(reset_n), .light(light), .color_code(code[2]),
    .illegal_code(ill[2]), .seq_error(seq[2]), .dwell_error(dwl[2]), .lock(lck[2]),
    .cycle_count(cyc2), .error_count(err2));

  // Behavioural model: one entry per instance, tracked as run lengths and counts.
  int p_dmin [3] = '{1, 2, 1};
  int p_dmax [3] = '{4, 4, 4};
  int p_lock [3] = '{3, 3, 3};
  int p_w    [3] = '{8, 8, 2};
  int m_track [3], m_col [3], m_run [3], m_chk [3], m_streak [3], m_cyc [3], m_err [3];
  int e_code [3], e_ill [3], e_seq [3], e_dwl [3], e_lock [3];

  function automatic int act_cyc(int i);
    if (i == 0) return int'(cyc0);
    if (i == 1) return int'(cyc1);
    return int'(cyc2);
  endfunction

  function automatic int act_err(int i);
    if (i == 0) return int'(err0);
    if (i == 1) return int'(err1);
    return int'(err2);
  endfunction

  task automatic model_update(input logic [2:0] l, input logic r);
    for (int i = 0; i < 3; i++) begin
      int c, good, yr;
      if (!r) begin
        m_track[i] = 0; m_col[i] = 0; m_run[i] = 0; m_chk[i] = 0;
        m_streak[i] = 0; m_cyc[i] = 0; m_err[i] = 0;
        e_code[i] = 0; e_ill[i] = 0; e_seq[i] = 0; e_dwl[i] = 0; e_lock[i] = 0;
      end else begin
        c = (l == 3'b100) ? 1 : (l == 3'b010) ? 2 : (l == 3'b001) ? 3 : 0;
        good = 0; yr = 0;
        e_ill[i] = 0; e_seq[i] = 0; e_dwl[i] = 0;
        if (c == 0) begin
          e_ill[i] = 1; m_track[i] = 0; m_run[i] = 0; m_chk[i] = 0;
        end else if (m_track[i] == 0) begin
          m_track[i] = 1; m_col[i] = c; m_run[i] = 1; m_chk[i] = 0;
        end else if (c == m_col[i]) begin
          if (m_run[i] <= p_dmax[i]) begin
            m_run[i]++;
            if (m_chk[i] != 0 && m_run[i] == p_dmax[i] + 1) e_dwl[i] = 1;
          end
        end else if (c == (m_col[i] % 3) + 1) begin
          if (m_chk[i] != 0 && m_run[i] < p_dmin[i]) e_dwl[i] = 1;
          if (m_col[i] == 3) yr = 1;
          good = (e_dwl[i] == 0);
          m_col[i] = c; m_run[i] = 1; m_chk[i] = 1;
        end else begin
          e_seq[i] = 1; m_col[i] = c; m_run[i] = 1; m_chk[i] = 0;
        end
        if (e_ill[i] + e_seq[i] + e_dwl[i] > 0) begin
          m_streak[i] = 0;
          if (m_err[i] < (1 << p_w[i]) - 1) m_err[i]++;
        end else if (good != 0 && m_streak[i] < p_lock[i]) begin
          m_streak[i]++;
        end
        m_cyc[i] = (m_cyc[i] + yr) % (1 << p_w[i]);
        e_code[i] = c;
        e_lock[i] = (m_streak[i] == p_lock[i]);
      end
    end
  endtask

  task automatic step(input logic [2:0] l, input logic r);
    light   = l;
    reset_n = r;
    @(posedge clock);
    model_update(l, r);
    #1;
  endtask

  task automatic test_reset();
    step(3'b101, 1'b0);
    step(3'b010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({code[i], ill[i], seq[i], dwl[i], lck[i]} !== 6'b0 || act_cyc(i) != 0 || act_err(i) != 0) begin
        nerr++;
        $display("FAIL reset[%0d] got code=%0d flags=%b%b%b%b cyc=%0d err=%0d want all 0",
                 i, code[i], ill[i], seq[i], dwl[i], lck[i], act_cyc(i), act_err(i));
      end
    end
  endtask

  task automatic test_sequence();
    logic [2:0] pat [5];
    logic [1:0] ec [5];
    logic       el [5];
    pat = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
    ec  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    el  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      step(pat[k], 1'b1);
      nvec++;
      if (code[0] !== ec[k]) begin nerr++; $display("FAIL seq_code[%0d] got %0d want %0d", k, code[0], ec[k]); end
      nvec++;
      if ({ill[0], seq[0], dwl[0]} !== 3'b000) begin nerr++; $display("FAIL seq_flags[%0d] got %b%b%b want 000", k, ill[0], seq[0], dwl[0]); end
      nvec++;
      if (lck[0] !== el[k]) begin nerr++; $display("FAIL seq_lock[%0d] got %b want %b", k, lck[0], el[k]); end
    end
    nvec++;
    if (cyc0 !== 8'd1) begin nerr++; $display("FAIL seq_cycles got %0d want 1", cyc0); end
    nvec++;
    if (err0 !== 8'd0) begin nerr++; $display("FAIL seq_errors got %0d want 0", err0); end
  endtask

  task automatic test_seq_error();
    step(3'b001, 1'b1);
    step(3'b100, 1'b1);
    nvec++;
    if (lck[0] !== 1'b1 || cyc0 !== 8'd2) begin nerr++; $display("FAIL serr_pre got lock=%b cyc=%0d want 1/2", lck[0], cyc0); end
    step(3'b001, 1'b1);
    nvec++;
    if (seq[0] !== 1'b1 || dwl[0] !== 1'b0) begin nerr++; $display("FAIL serr_pulse got seq=%b dwl=%b want 1/0", seq[0], dwl[0]); end
    nvec++;
    if (lck[0] !== 1'b0 || err0 !== 8'd1) begin nerr++; $display("FAIL serr_after got lock=%b err=%0d want 0/1", lck[0], err0); end
    step(3'b100, 1'b1);
    nvec++;
    if ({ill[0], seq[0], dwl[0]} !== 3'b000 || err0 !== 8'd1) begin
      nerr++; $display("FAIL serr_next got flags=%b%b%b err=%0d want 000/1", ill[0], seq[0], dwl[0], err0);
    end
  endtask

  task automatic test_illegal();
    step(3'b110, 1'b1);
    nvec++;
    if (ill[0] !== 1'b1 || code[0] !== 2'd0 || seq[0] !== 1'b0 || dwl[0] !== 1'b0) begin
      nerr++; $display("FAIL ill_pulse got ill=%b code=%0d seq=%b dwl=%b want 1/0/0/0", ill[0], code[0], seq[0], dwl[0]);
    end
    nvec++;
    if (err0 !== 8'd2) begin nerr++; $display("FAIL ill_count got %0d want 2", err0); end
    step(3'b010, 1'b1);
    nvec++;
    if (ill[0] !== 1'b0 || seq[0] !== 1'b0 || code[0] !== 2'd2) begin
      nerr++; $display("FAIL ill_recover got ill=%b seq=%b code=%0d want 0/0/2", ill[0], seq[0], code[0]);
    end
  endtask

  task automatic test_dwell_max();
    step(3'b000, 1'b0);
    step(3'b100, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(3'b010, 1'b1);
      nvec++;
      if (dwl[0] !== (k == 5)) begin nerr++; $display("FAIL dmax_G%0d got %b want %b", k, dwl[0], (k == 5)); end
    end
    step(3'b001, 1'b1);
    nvec++;
    if ({ill[0], seq[0], dwl[0]} !== 3'b000 || err0 !== 8'd1) begin
      nerr++; $display("FAIL dmax_exit got flags=%b%b%b err=%0d want 000/1", ill[0], seq[0], dwl[0], err0);
    end
  endtask

  task automatic test_dwell_min();
    logic [2:0] pat [4];
    logic       ed [4];
    pat = '{3'b100, 3'b100, 3'b010, 3'b001};
    ed  = '{1'b0, 1'b0, 1'b0, 1'b1};
    step(3'b000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(pat[k], 1'b1);
      nvec++;
      if (dwl[1] !== ed[k] || seq[1] !== 1'b0 || lck[1] !== 1'b0) begin
        nerr++; $display("FAIL dmin[%0d] got dwl=%b seq=%b lock=%b want %b/0/0", k, dwl[1], seq[1], lck[1], ed[k]);
      end
    end
  endtask

  task automatic test_counter_sat();
    logic [2:0] pat [5];
    logic [1:0] ee  [5];
    pat = '{3'b000, 3'b110, 3'b111, 3'b011, 3'b101};
    ee  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(pat[k], 1'b1);
      nvec++;
      if (err2 !== ee[k] || ill[2] !== 1'b1) begin nerr++; $display("FAIL sat[%0d] got err=%0d ill=%b want %0d/1", k, err2, ill[2], ee[k]); end
    end
    step(3'b010, 1'b1);
    step(3'b010, 1'b0);
    nvec++;
    if ({code[0], ill[0], seq[0], dwl[0], lck[0]} !== 6'b0 || cyc0 !== 8'd0 || err0 !== 8'd0 || err2 !== 2'd0) begin
      nerr++; $display("FAIL midreset got code=%0d flags=%b%b%b%b cyc=%0d err=%0d err2=%0d want all 0",
                       code[0], ill[0], seq[0], dwl[0], lck[0], cyc0, err0, err2);
    end
    step(3'b100, 1'b1);
    nvec++;
    if (seq[0] !== 1'b0 || code[0] !== 2'd1) begin nerr++; $display("FAIL post_reset got seq=%b code=%0d want 0/1", seq[0], code[0]); end
  endtask

  task automatic test_random();
    int col, r;
    logic [2:0] l;
    logic [2:0] onehot [3];
    onehot = '{3'b100, 3'b010, 3'b001};
    col = 0;
    step(3'b000, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      l = onehot[col];
      if (r < 40) l = onehot[col];
      else if (r < 80) begin col = (col + 1) % 3; l = onehot[col]; end
      else if (r < 90) begin col = $urandom_range(0, 2); l = onehot[col]; end
      else l = 3'($urandom_range(0, 7));
      step(l, (r != 99));
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (int'(code[i]) != e_code[i]) begin nerr++; $display("FAIL rnd_code[%0d] n=%0d got %0d want %0d", i, n, code[i], e_code[i]); end
        nvec++;
        if (int'(ill[i]) != e_ill[i]) begin nerr++; $display("FAIL rnd_ill[%0d] n=%0d got %b want %0d", i, n, ill[i], e_ill[i]); end
        nvec++;
        if (int'(seq[i]) != e_seq[i]) begin nerr++; $display("FAIL rnd_seq[%0d] n=%0d got %b want %0d", i, n, seq[i], e_seq[i]); end
        nvec++;
        if (int'(dwl[i]) != e_dwl[i]) begin nerr++; $display("FAIL rnd_dwell[%0d] n=%0d got %b want %0d", i, n, dwl[i], e_dwl[i]); end
        nvec++;
        if (int'(lck[i]) != e_lock[i]) begin nerr++; $display("FAIL rnd_lock[%0d] n=%0d got %b want %0d", i, n, lck[i], e_lock[i]); end
        nvec++;
        if (act_cyc(i) != m_cyc[i]) begin nerr++; $display("FAIL rnd_cycles[%0d] n=%0d got %0d want %0d", i, n, act_cyc(i), m_cyc[i]); end
        nvec++;
        if (act_err(i) != m_err[i]) begin nerr++; $display("FAIL rnd_errors[%0d] n=%0d got %0d want %0d", i, n, act_err(i), m_err[i]); end
      end
    end
  endtask

  initial begin
    light   = 3'b000;
    reset_n = 1'b0;
    test_reset();
    test_sequence();
    test_seq_error();
    test_illegal();
    test_dwell_max();
    test_dwell_min();
    test_counter_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lamp_sequence_checker.md
Name: lamp_sequence_checker

Overview:
Receive-side monitor for the 3-bit RGY one-hot lamp bus driven by the cyclic lamp controller.
- Decodes the lamp code each clock and checks that colours follow the legal order RED -> GREEN -> YELLOW -> RED.
- Checks dwell time per colour and reports protocol errors, lock status, completed cycles and a saturating error count.
- Sits beside the lamp driver in test benches and system builds as the checker at the far end of the lamp bus.

Parameters:
DWELL_MIN, 1, minimum consecutive samples a colour must be held before a legal change
DWELL_MAX, 4, maximum consecutive samples a colour may be held before dwell_error
LOCK_CNT, 3, consecutive error-free legal transitions required to assert lock
CNT_W, 8, width of cycle_count and error_count

Ports:
clock  input  1  rising-edge clock, same clock as the lamp driver
reset_n  input  1  synchronous active-low reset
light  input  [0:2]  lamp bus, RGY order: 3'b100 RED, 3'b010 GREEN, 3'b001 YELLOW
color_code  output  2  decoded colour: 0 none/illegal, 1 RED, 2 GREEN, 3 YELLOW
illegal_code  output  1  one-cycle pulse: sampled light was not exactly one-hot
seq_error  output  1  one-cycle pulse: colour change not in legal order
dwell_error  output  1  one-cycle pulse: dwell below DWELL_MIN at a change, or above DWELL_MAX while holding
lock  output  1  high after LOCK_CNT consecutive error-free legal transitions
cycle_count  output  CNT_W  count of legal YELLOW->RED transitions, wraps at 2^CNT_W
error_count  output  CNT_W  count of samples with any error flag, saturates at all-ones

Behaviour:
Reset and timing
- Reset (reset_n low at a rising edge): all outputs 0, FSM = HUNT, dwell counter 0, checked flag 0, transition counter 0. A reset mid-stream discards all history.
- All outputs are registered. `light` sampled at edge k is reflected in outputs during the cycle after edge k (1-cycle latency).
- Error flags are pulses, high for exactly one cycle per offending sample.

State machine: HUNT, TRACK
- HUNT: no valid previous colour.
  - Legal code -> TRACK; record colour; dwell = 1; checked = 0 (first segment is partial, no dwell checks).
  - Illegal code -> stay in HUNT.
- TRACK, same colour sampled:
  - dwell increments, saturating at DWELL_MAX+1.
  - If checked = 1 and dwell becomes DWELL_MAX+1: dwell_error pulses once; it does not repeat while the colour is held.
- TRACK, legal successor sampled (R->G, G->Y, Y->R):
  - If checked = 1 and old dwell < DWELL_MIN: dwell_error.
  - New colour recorded, dwell = 1, checked = 1.
  - Y->R increments cycle_count.
- TRACK, any other one-hot change:
  - seq_error pulses.
  - New colour recorded, dwell = 1, checked = 0. No dwell check on that sample.
- Illegal code in any state:
  - illegal_code pulses; color_code = 0; FSM -> HUNT.
  - Illegal takes priority: no seq_error or dwell_error on that sample.
  - An illegal sample from HUNT also pulses and counts as an error.

Lock and counters
- Transition counter increments on each error-free legal transition and saturates at LOCK_CNT.
- lock = (counter == LOCK_CNT). Any error flag clears the counter and lock in the same update.
- error_count increments by exactly 1 per sample with one or more error flags (seq_error and dwell_error together count once). It holds at all-ones.
- color_code always reflects the most recent sample: 0 when the sample is illegal.

Test Plan:
1. Reset, then light R,G,Y,R,G one sample each -> color_code 1,2,3,1,2; no error pulses; lock rises in the cycle after the Y->R sample (3rd transition); cycle_count=1; error_count=0.
2. After lock, drive R then Y -> seq_error one cycle, lock=0, error_count=1; following R sample gives no error and no dwell check.
3. Drive light=3'b110 while in TRACK -> illegal_code one cycle, color_code=0, FSM HUNT, error_count+1; next 3'b010 enters TRACK with no seq_error.
4. Legal R->G, then hold G for 5 samples (DWELL_MAX=4) -> dwell_error exactly once, on the 5th G sample; a 6th G gives no pulse; then Y gives no error and no dwell_error.
5. Instance with DWELL_MIN=2: sequence R,R,G,Y -> dwell_error on the Y sample, no seq_error, lock stays 0.
6. Instance with CNT_W=2: 5 illegal samples -> error_count 1,2,3,3,3. Then hold reset_n low for one edge mid-stream -> all outputs 0, next legal sample gives no seq_error.
